// File: rtl/alp_seq_pkg.sv
// Shared types and constants for the ALP multi-cycle shift/multiply sequencer.
package alp_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_ZERO = 4'b1000;
    localparam logic [3:0] ALU_SHL  = 4'b1100;
    localparam logic [3:0] ALU_SHR  = 4'b1101;

    // Slice opcode issued during a STEP cycle for the latched command.
    function automatic logic [3:0] step_opcode(input logic [1:0] op);
        case (op)
            OP_SHL:  return ALU_SHL;
            OP_MUL:  return ALU_ADD;
            default: return ALU_SHR;
        endcase
    endfunction

endpackage

// File: rtl/alp_seq_cnt.sv
// Loadable step down-counter; load values above STEPS_MAX are clamped.
module alp_seq_cnt
    import alp_seq_pkg::*;
#(
    parameter int STEPS_MAX = 32,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset_h,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    localparam logic [CNT_W-1:0] CLAMP = CNT_W'(STEPS_MAX);

    logic [CNT_W-1:0] value;

    always_ff @(posedge clk) begin
        if (reset_h) begin
            value <= '0;
        end else if (load) begin
            value <= (load_val > CLAMP) ? CLAMP : load_val;
        end else if (dec && value != '0) begin
            value <= value - CNT_W'(1);
        end
    end

    assign last = (value == CNT_W'(1));

endmodule

// File: rtl/alp_seq.sv
// ALP ALU sequencer: owns the slice chain for one shift or multiply command,
// stepping it for N cycles and reporting completion and SHL overflow.
module alp_seq
    import alp_seq_pkg::*;
#(
    parameter int STEPS_MAX = 32,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset_h,
    input  logic             start_h,
    input  logic [1:0]       op_h,
    input  logic [CNT_W-1:0] count_h,
    input  logic             abort_h,
    input  logic             mq_lsb_h,
    input  logic             sign_in_h,
    input  logic             v_in_h,
    output logic [3:0]       alu_h,
    output logic             pass_a_h,
    output logic             carry_in_h,
    output logic             shift_fill_h,
    output logic             q_shift_h,
    output logic             busy_h,
    output logic             done_h,
    output logic             ovf_h
);

    state_t           state, state_n;
    logic [1:0]       op_q;
    logic             ovf_q;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_last;

    alp_seq_cnt #(
        .STEPS_MAX(STEPS_MAX),
        .CNT_W    (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset_h (reset_h),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .last    (cnt_last)
    );

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = count_h;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_h) begin
                    accept = 1'b1;
                    if (op_h == OP_MUL) begin
                        state_n = ST_CLR;
                    end else if (count_h != '0) begin
                        cnt_load = 1'b1;
                        state_n  = ST_STEP;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_CLR: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(STEPS_MAX);
                state_n  = ST_STEP;
            end
            ST_STEP: begin
                cnt_dec = 1'b1;
                if (cnt_last) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        // Cancel wins over any accept or advance in the same cycle.
        if (abort_h) begin
            state_n  = ST_IDLE;
            accept   = 1'b0;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_h) begin
            state <= ST_IDLE;
            op_q  <= OP_SHL;
            ovf_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q  <= op_h;
                ovf_q <= 1'b0;
            end else if (state == ST_STEP && op_q == OP_SHL && !abort_h) begin
                ovf_q <= ovf_q | v_in_h;
            end
        end
    end

    always_comb begin
        alu_h        = ALU_NOP;
        pass_a_h     = 1'b0;
        carry_in_h   = 1'b0;
        shift_fill_h = 1'b0;
        q_shift_h    = 1'b0;
        busy_h       = 1'b0;
        done_h       = 1'b0;
        case (state)
            ST_CLR: begin
                alu_h  = ALU_ZERO;
                busy_h = 1'b1;
            end
            ST_STEP: begin
                alu_h        = step_opcode(op_q);
                busy_h       = 1'b1;
                pass_a_h     = (op_q == OP_MUL) & ~mq_lsb_h;
                q_shift_h    = (op_q == OP_MUL);
                shift_fill_h = (op_q == OP_SRA) & sign_in_h;
            end
            ST_DONE: done_h = 1'b1;
            default: ;
        endcase
    end

    assign ovf_h = ovf_q;

endmodule

// File: tb/tb_alp_seq.sv
// Scoreboard bench for alp_seq: the driver builds each command's phase schedule
// and queues per-cycle expected outputs; a negedge monitor pops and compares.
module tb_alp_seq;
    import alp_seq_pkg::*;

    localparam int STEPS_MAX = 32;
    localparam int CNT_W     = 6;
    localparam int PH_IDLE = 0, PH_CLR = 1, PH_STEP = 2, PH_DONE = 3;

    logic             clk = 1'b0;
    logic             reset_h = 1'b1;
    logic             start_h = 1'b0;
    logic [1:0]       op_h = 2'b00;
    logic [CNT_W-1:0] count_h = '0;
    logic             abort_h = 1'b0;
    logic             mq_lsb_h = 1'b0;
    logic             sign_in_h = 1'b0;
    logic             v_in_h = 1'b0;
    logic [3:0]       alu_h;
    logic             pass_a_h, carry_in_h, shift_fill_h, q_shift_h;
    logic             busy_h, done_h, ovf_h;

    always #5 clk = ~clk;

    alp_seq #(.STEPS_MAX(STEPS_MAX), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_h     (reset_h),
        .start_h     (start_h),
        .op_h        (op_h),
        .count_h     (count_h),
        .abort_h     (abort_h),
        .mq_lsb_h    (mq_lsb_h),
        .sign_in_h   (sign_in_h),
        .v_in_h      (v_in_h),
        .alu_h       (alu_h),
        .pass_a_h    (pass_a_h),
        .carry_in_h  (carry_in_h),
        .shift_fill_h(shift_fill_h),
        .q_shift_h   (q_shift_h),
        .busy_h      (busy_h),
        .done_h      (done_h),
        .ovf_h       (ovf_h)
    );

    typedef logic [10:0] exp_t;  // {alu[3:0], pass_a, carry, fill, q_shift, busy, done, ovf}
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  model_ovf = 1'b0;
    string cur_name = "reset";

    function automatic exp_t expect_out(input int ph, input logic [1:0] op,
                                        input logic mq, input logic sgn, input logic ovf);
        logic [3:0] alu;
        logic pa, fill, qs, busy, done;
        alu = ALU_NOP; pa = 1'b0; fill = 1'b0; qs = 1'b0; busy = 1'b0; done = 1'b0;
        if (ph == PH_CLR) begin
            alu = ALU_ZERO; busy = 1'b1;
        end else if (ph == PH_STEP) begin
            busy = 1'b1;
            if (op == OP_MUL) begin
                alu = ALU_ADD; pa = ~mq; qs = 1'b1;
            end else if (op == OP_SHL) begin
                alu = ALU_SHL;
            end else begin
                alu = ALU_SHR; fill = (op == OP_SRA) ? sgn : 1'b0;
            end
        end else if (ph == PH_DONE) begin
            done = 1'b1;
        end
        return {alu, pa, 1'b0, fill, qs, busy, done, ovf};
    endfunction

    exp_t e_mon, a_mon;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            a_mon = {alu_h, pass_a_h, carry_in_h, shift_fill_h, q_shift_h, busy_h, done_h, ovf_h};
            n_checks++;
            if (a_mon !== e_mon) begin
                n_fail++;
                $display("FAIL %s t=%0t got alu=%b pa=%b ci=%b sf=%b qs=%b busy=%b done=%b ovf=%b, want alu=%b pa=%b ci=%b sf=%b qs=%b busy=%b done=%b ovf=%b",
                         cur_name, $time, a_mon[10:7], a_mon[6], a_mon[5], a_mon[4], a_mon[3],
                         a_mon[2], a_mon[1], a_mon[0], e_mon[10:7], e_mon[6], e_mon[5],
                         e_mon[4], e_mon[3], e_mon[2], e_mon[1], e_mon[0]);
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start_h = 1'b0; abort_h = 1'b0; reset_h = 1'b0;
            v_in_h = 1'($urandom); mq_lsb_h = 1'($urandom); sign_in_h = 1'($urandom);
            exp_q.push_back(expect_out(PH_IDLE, OP_SHL, mq_lsb_h, sign_in_h, model_ovf));
        end
    endtask

    // pat 0: random inputs; 1: v_in only on step 2, mq_lsb odd steps, sign 1; 2: v_in and sign always 1
    task automatic run_cmd(input string name, input logic [1:0] op, input int cnt,
                           input int abort_at, input int rst_at, input int restart_at, input int pat);
        int sched[$];
        int nsteps, ph, stepno;
        cur_name = name;
        nsteps = (op == OP_MUL) ? STEPS_MAX : ((cnt > STEPS_MAX) ? STEPS_MAX : cnt);
        if (op == OP_MUL) sched.push_back(PH_CLR);
        for (int i = 0; i < nsteps; i++) sched.push_back(PH_STEP);
        sched.push_back(PH_DONE);

        @(posedge clk); #1;
        start_h = 1'b1; op_h = op; count_h = CNT_W'(cnt); abort_h = 1'b0; reset_h = 1'b0;
        v_in_h = 1'($urandom); mq_lsb_h = 1'($urandom); sign_in_h = 1'($urandom);
        exp_q.push_back(expect_out(PH_IDLE, op, mq_lsb_h, sign_in_h, model_ovf));
        model_ovf = 1'b0;
        stepno = 0;

        for (int k = 1; k <= sched.size(); k++) begin
            @(posedge clk); #1;
            ph = sched[k-1];
            start_h = (k == restart_at);
            if (start_h) begin
                op_h = 2'($urandom); count_h = CNT_W'($urandom_range(0, 40));
            end
            abort_h = (k == abort_at);
            reset_h = (k == rst_at);
            if (ph == PH_STEP) stepno++;
            if (pat == 1) begin
                v_in_h = (stepno == 2) && (ph == PH_STEP); mq_lsb_h = stepno[0]; sign_in_h = 1'b1;
            end else if (pat == 2) begin
                v_in_h = 1'b1; mq_lsb_h = 1'($urandom); sign_in_h = 1'b1;
            end else begin
                v_in_h = 1'($urandom); mq_lsb_h = 1'($urandom); sign_in_h = 1'($urandom);
            end
            exp_q.push_back(expect_out(ph, op, mq_lsb_h, sign_in_h, model_ovf));
            if (reset_h) begin
                model_ovf = 1'b0;
                break;
            end
            if (abort_h) break;
            if (ph == PH_STEP && op == OP_SHL) model_ovf = model_ovf | v_in_h;
        end
    endtask

    initial begin
        int abort_at, restart_at, cnt;
        logic [1:0] op;
        reset_h = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(expect_out(PH_IDLE, OP_SHL, mq_lsb_h, sign_in_h, 1'b0));
        idle_cycles(2);

        run_cmd("shl3_ovf",   OP_SHL, 3, -1, -1, -1, 1);
        run_cmd("sra2_fill",  OP_SRA, 2, -1, -1, -1, 1);
        run_cmd("shr2_nofill", OP_SHR, 2, -1, -1, -1, 1);
        run_cmd("mul_alt",    OP_MUL, 0, -1, -1, -1, 1);
        run_cmd("shl_cnt0",   OP_SHL, 0, -1, -1, -1, 0);
        run_cmd("shl_cnt40",  OP_SHL, 40, -1, -1, -1, 0);
        run_cmd("mul_abort",  OP_MUL, 0, 6, -1, -1, 0);
        idle_cycles(1);
        run_cmd("shl_abort_hold", OP_SHL, 6, 3, -1, -1, 2);
        idle_cycles(1);
        run_cmd("shr_busy_start", OP_SHR, 10, -1, -1, 4, 0);
        run_cmd("sra_done_start", OP_SRA, 3, -1, -1, 4, 0);
        run_cmd("shl_reset",  OP_SHL, 8, -1, 5, -1, 2);
        idle_cycles(1);

        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom);
            cnt = $urandom_range(0, 40);
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : -1;
            restart_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1;
            if (restart_at == abort_at) restart_at = -1;
            run_cmd("random", op, cnt, abort_at, -1, restart_at, 0);
        end
        idle_cycles(2);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain %0d expected entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t limit reached, want completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alp_seq.md
# alp_seq

Multi-cycle sequencer for the ALP ALU slice chain. It accepts one shift or multiply command and, over N cycles, drives the slice opcode, pass-A, carry and shift-fill controls, sampling datapath flags as it goes. It sits between microcode dispatch and the ALP slices and owns the ALU for the whole command.

## Interface
Parameters:
- STEPS_MAX, 32, multiply step count and clamp for shift counts.
- CNT_W, 6, step counter width; must satisfy 2^CNT_W > STEPS_MAX.

Ports:
- clk  in  1  datapath clock, all state updates on the rising edge.
- reset_h  in  1  synchronous, active-high reset.
- start_h  in  1  command strobe; accepted only in IDLE.
- op_h  in  2  command: 00 SHL, 01 SHR logical, 10 SHR arithmetic, 11 MUL.
- count_h  in  CNT_W  shift count; ignored for MUL.
- abort_h  in  1  synchronous cancel.
- mq_lsb_h  in  1  multiplier LSB from the Q register.
- sign_in_h  in  1  operand sign bit, for arithmetic shift fill.
- v_in_h  in  1  slice-chain overflow for the current step.
- alu_h  out  4  slice opcode.
- pass_a_h  out  1  slice pass-A control.
- carry_in_h  out  1  chain carry in.
- shift_fill_h  out  1  bit shifted into the vacated end.
- q_shift_h  out  1  shift the Q register this cycle.
- busy_h  out  1  command in progress.
- done_h  out  1  one-cycle completion pulse.
- ovf_h  out  1  sticky SHL overflow.

## Operation
- States: IDLE, CLR, STEP, DONE. Outputs are Moore decodes of the state register, except pass_a_h and shift_fill_h in STEP.
- IDLE with start_h:
  - MUL: go to CLR.
  - Shift with clamped count nonzero: load counter, go to STEP.
  - Shift with count 0: go to DONE.
  - In all cases clear ovf_h and latch op_h.
- count_h > STEPS_MAX is clamped to STEPS_MAX.
- CLR (MUL only): alu_h=ALU_ZERO, load counter with STEPS_MAX, go to STEP.
- STEP, per op:
  - SHL: alu_h=ALU_SHL, shift_fill_h=0, ovf_h |= v_in_h.
  - SHR logical: alu_h=ALU_SHR, shift_fill_h=0.
  - SHR arithmetic: alu_h=ALU_SHR, shift_fill_h=sign_in_h.
  - MUL: alu_h=ALU_ADD, pass_a_h=~mq_lsb_h, q_shift_h=1, shift_fill_h=0.
  - Every STEP cycle decrements the counter. When counter==1, go to DONE.
- DONE: done_h=1, go to IDLE.
- busy_h=1 in CLR and STEP. It is 0 in DONE and IDLE.
- abort_h overrides start_h and every transition: next state IDLE, no done_h pulse, ovf_h holds its value.
- start_h outside IDLE is ignored with no queuing. start_h in DONE is also ignored.
- carry_in_h is 0 in every state.

## Timing
- Reset values: state IDLE, alu_h=ALU_NOP, pass_a_h=0, carry_in_h=0, shift_fill_h=0, q_shift_h=0, busy_h=0, done_h=0, ovf_h=0, counter=0.
- Reset mid-command: IDLE on the next edge with all outputs at reset values; ovf_h is cleared.
- start_h sampled at edge 0. For shift count N≥1: STEP during cycles 1..N, done_h in cycle N+1, IDLE in cycle N+2.
- Shift count 0: done_h in cycle 1.
- MUL: CLR in cycle 1, STEP in cycles 2..33, done_h in cycle 34.
- Back-to-back: a new start_h is accepted in the first IDLE cycle after DONE.
- ovf_h updates on the edge ending each SHL STEP cycle. It is valid when done_h is asserted.

## Structure
- Package alp_seq_pkg holds:
  - state enum.
  - op_h encodings.
  - opcode constants: ALU_NOP=4'b0000, ALU_ADD=4'b0100, ALU_ZERO=4'b1000, ALU_SHL=4'b1100, ALU_SHR=4'b1101.
- Sub-module alp_seq_cnt: loadable CNT_W down-counter with clamp-on-load and a last_h flag (count==1).
- The top level holds the FSM, the op latch, the ovf register and the output decode.

## Test plan
- Reset, then SHL count 3 with v_in_h=0,1,0 across the steps -> alu_h=4'b1100 for exactly 3 cycles, done_h in cycle 4, ovf_h=1.
- SHR arithmetic count 2 with sign_in_h=1 -> alu_h=4'b1101 and shift_fill_h=1 for 2 cycles; SHR logical gives shift_fill_h=0.
- MUL with mq_lsb_h alternating 1,0 -> cycle 1 alu_h=4'b1000; 32 STEP cycles with pass_a_h=0,1,0,1…; q_shift_h=1 in each STEP; done_h in cycle 34.
- Shift count 0 -> done_h in cycle 1, busy_h never 1. Count 40 -> exactly 32 steps.
- abort_h at step 5 of MUL -> IDLE next cycle, no done_h. start_h during busy is ignored, and the step count is unchanged.
- reset_h asserted mid-SHL with ovf_h=1 -> next cycle all outputs at reset values, ovf_h=0.
